// File: rtl/ntt_buffer_ctrl.sv
// ntt_buffer_ctrl: sequencing controller for the NTT 4-lane reorder buffer.
// Accepts 4-coefficient words upstream, drives the buffer wren/rden/count-reset
// strobes and presents each reorganised group of 4 words downstream. Filling of
// group g+1 overlaps draining of group g within the per-lane slot headroom.
// Optional build macro: NTT_BUF_CTRL_REG_READY_EN (in_ready ignores the
// same-cycle read, removing the out_ready -> in_ready combinational path).
module ntt_buffer_ctrl #(
  parameter int unsigned NUM_GROUPS = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic zeroize,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  input  logic out_ready,
  output logic out_valid,
  output logic buf_wren,
  output logic buf_rden,
  output logic buf_wr_rst_count,
  output logic buf_rd_rst_count,
  output logic busy,
  output logic done
);

  localparam int unsigned GRP_W = $clog2(NUM_GROUPS + 1);
  localparam int unsigned TOT_W = GRP_W + 2;
  localparam logic [TOT_W-1:0] WR_LIMIT  = TOT_W'(4 * NUM_GROUPS);
  localparam logic [GRP_W-1:0] GRP_LIMIT = GRP_W'(NUM_GROUPS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [2:0]         wr_in_grp;
  logic [1:0]         rd_idx;
  logic               rd_active;
  logic [TOT_W-1:0]   wr_total;
  logic [GRP_W-1:0]   rd_grp;
  logic [GRP_W-1:0]   rd_grp_nxt;

  logic               clr;
  logic               start_acc;
  logic               wr_fire;
  logic               rd_fire;
  logic               rd_last;
  logic               grp_done;
  logic               allow;
  logic [2:0]         allow_lhs;
  logic [2:0]         allow_rhs;

  // Handshake strobes, write allowance and pass-level outputs.
  always_comb begin
    clr        = !reset_n || zeroize;
    start_acc  = (state == ST_IDLE) && start;
    out_valid  = rd_active;
    rd_fire    = out_valid && out_ready;
    rd_last    = rd_fire && (rd_idx == 2'd3);
    allow_lhs  = wr_in_grp + 3'd1;
`ifdef NTT_BUF_CTRL_REG_READY_EN
    allow_rhs  = {1'b0, rd_idx};
`else
    allow_rhs  = {1'b0, rd_idx} + {2'b00, rd_fire};
`endif
    // Write k of the next group may only shift lane k once read k of the
    // draining group has happened (or is happening now).
    allow      = !rd_active || (allow_lhs <= allow_rhs);
    in_ready   = (state == ST_RUN) && (wr_total < WR_LIMIT) && allow;
    wr_fire    = in_valid && in_ready;
    grp_done   = wr_fire && (wr_in_grp == 3'd3);
    buf_wren   = wr_fire;
    buf_rden   = rd_fire;
    rd_grp_nxt = rd_grp + GRP_W'(rd_last);
    buf_wr_rst_count = start_acc && reset_n && !zeroize;
    buf_rd_rst_count = start_acc && reset_n && !zeroize;
    busy       = (state != ST_IDLE);
    done       = (state == ST_DONE);
  end

  // Next-state selection for the pass sequencer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (wr_total == WR_LIMIT) state_nxt = ST_DRAIN;
      // Leave on the completing read so DONE directly follows the last read.
      ST_DRAIN: if (rd_grp_nxt == GRP_LIMIT) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset and zeroize abort any pass in progress.
  always_ff @(posedge clk) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Write/read progress counters and the draining-group flag.
  always_ff @(posedge clk) begin
    if (clr || start_acc) begin
      wr_in_grp <= '0;
      rd_idx    <= '0;
      rd_active <= 1'b0;
      wr_total  <= '0;
      rd_grp    <= '0;
    end else begin
      wr_total <= wr_total + TOT_W'(wr_fire);
      rd_grp   <= rd_grp_nxt;
      if (grp_done)     wr_in_grp <= '0;
      else if (wr_fire) wr_in_grp <= wr_in_grp + 3'd1;
      // A completing write while draining always coincides with the 4th read,
      // so both branches agree on rd_idx returning to 0.
      if (grp_done || rd_last) rd_idx <= '0;
      else if (rd_fire)        rd_idx <= rd_idx + 2'd1;
      if (grp_done)     rd_active <= 1'b1;
      else if (rd_last) rd_active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ntt_buffer_ctrl.sv
// Directed bench for ntt_buffer_ctrl with NUM_GROUPS=2.
module tb_ntt_buffer_ctrl;

  localparam int unsigned G = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic zeroize = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, buf_wren, buf_rden;
  logic buf_wr_rst_count, buf_rd_rst_count, busy, done;

  int errors = 0;
  int checks = 0;
  int nw, nr, nd;
  bit seen;

  ntt_buffer_ctrl #(.NUM_GROUPS(G)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .zeroize          (zeroize),
    .start            (start),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .buf_wren         (buf_wren),
    .buf_rden         (buf_rden),
    .buf_wr_rst_count (buf_wr_rst_count),
    .buf_rd_rst_count (buf_rd_rst_count),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full-rate pass: writes in cycles 1..8, reads 5..12, done at 13, idle at 14.
  task automatic full_pass(input string nm, input bit poke_start);
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1; zeroize = 1'b0;
    #1;
    chk({nm, " c0 wr_rst"}, buf_wr_rst_count, 1'b1);
    chk({nm, " c0 rd_rst"}, buf_rd_rst_count, 1'b1);
    chk({nm, " c0 in_ready"}, in_ready, 1'b0);
    chk({nm, " c0 busy"}, busy, 1'b0);
    tick;
    start = 1'b0;
    nw = 0; nr = 0; nd = 0;
    for (int c = 1; c <= 14; c++) begin
      start = poke_start && (c == 10);
      #1;
      chk($sformatf("%s c%0d in_ready", nm, c), in_ready, (c <= 8));
      chk($sformatf("%s c%0d wren", nm, c), buf_wren, (c <= 8));
      chk($sformatf("%s c%0d out_valid", nm, c), out_valid, (c >= 5 && c <= 12));
      chk($sformatf("%s c%0d rden", nm, c), buf_rden, (c >= 5 && c <= 12));
      chk($sformatf("%s c%0d done", nm, c), done, (c == 13));
      chk($sformatf("%s c%0d busy", nm, c), busy, (c <= 13));
      chk($sformatf("%s c%0d wr_rst", nm, c), buf_wr_rst_count, 1'b0);
      chk($sformatf("%s c%0d rd_rst", nm, c), buf_rd_rst_count, 1'b0);
      if (buf_wren) nw++;
      if (buf_rden) nr++;
      if (done) nd++;
      tick;
    end
    start = 1'b0;
    chki({nm, " writes"}, nw, 4 * G);
    chki({nm, " reads"}, nr, 4 * G);
    chki({nm, " done_pulses"}, nd, 1);
  endtask

  initial begin
    // Reset held with start asserted: everything quiet, no count-reset strobes.
    reset_n = 1'b0; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick; tick;
    chk("rst wr_rst", buf_wr_rst_count, 1'b0);
    chk("rst rd_rst", buf_rd_rst_count, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst in_ready", in_ready, 1'b0);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst wren", buf_wren, 1'b0);
    chk("rst rden", buf_rden, 1'b0);
    start = 1'b0; reset_n = 1'b1;
    tick;

    // Continuous traffic, including coincident 4th write / 4th read.
    full_pass("full", 1'b0);

    // Start pulsed during DRAIN must be ignored.
    full_pass("ign", 1'b1);

    // Downstream stall.
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1; chk($sformatf("stall c%0d in_ready", c), in_ready, 1'b1); tick;
    end
    for (int c = 5; c <= 7; c++) begin
      #1;
      chk($sformatf("stall c%0d in_ready rd0", c), in_ready, 1'b0);
      chk($sformatf("stall c%0d out_valid", c), out_valid, 1'b1);
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 8; c <= 9; c++) begin
      #1;
      chk($sformatf("stall c%0d rden", c), buf_rden, 1'b1);
      chk($sformatf("stall c%0d wren", c), buf_wren, 1'b0);
      tick;
    end
    in_valid = 1'b1; out_ready = 1'b0;
    for (int c = 10; c <= 11; c++) begin
      #1; chk($sformatf("stall c%0d in_ready rd2", c), in_ready, 1'b1); tick;
    end
    for (int c = 12; c <= 13; c++) begin
      #1;
      chk($sformatf("stall c%0d in_ready blocked", c), in_ready, 1'b0);
      chk($sformatf("stall c%0d out_valid", c), out_valid, 1'b1);
      tick;
    end
    out_ready = 1'b1;
    nw = 0; nr = 0; nd = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      #1;
      if (buf_wren) nw++;
      if (buf_rden) nr++;
      if (done) begin nd++; seen = 1'b1; end
      tick;
    end
    chk("stall done_seen", seen, 1'b1);
    chki("stall tail writes", nw, 2);
    chki("stall tail reads", nr, 6);
    chki("stall done_pulses", nd, 1);
    #1; chk("stall idle busy", busy, 1'b0);

    // Zeroize after 6 writes aborts the pass.
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 4; c++) tick;
    out_ready = 1'b1;
    for (int c = 5; c <= 6; c++) begin
      #1; chk($sformatf("zero c%0d in_ready", c), in_ready, 1'b1); tick;
    end
    zeroize = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick;
    zeroize = 1'b0;
    #1;
    chk("zero busy", busy, 1'b0);
    chk("zero in_ready", in_ready, 1'b0);
    chk("zero out_valid", out_valid, 1'b0);
    chk("zero done", done, 1'b0);
    in_valid = 1'b1; out_ready = 1'b1;
    nd = 0;
    for (int c = 0; c < 5; c++) begin
      tick;
      chk($sformatf("zero idle%0d in_ready", c), in_ready, 1'b0);
      if (done) nd++;
    end
    chki("zero no_done", nd, 0);

    // Fresh pass after the abort.
    full_pass("restart", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
